mod53_serial_reduce: RTL and testbench
======================================

// Module: mod53_serial_reduce
// PURPOSE
// - Upstream stage of the mod-53 datapath. Reduces a wide unsigned operand to a
//   canonical residue 0..MOD-1.
// - The result drives the 6-bit residue input of the downstream constant-multiply
//   LUT stages. Those stages are only defined for inputs 0..52.
// - Bit-serial, MSB first: r <= (2r + b) mod MOD, one operand bit per clock.
//   Valid/ready handshake on both sides.
// PARAMETERS
// - IN_W   16  operand width in bits, >= 2
// - MOD    53  modulus, 2 <= MOD <= 2**RES_W
// - RES_W  6   residue width in bits
// PORTS
// - clk        in   1      clock; all state updates on rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      in_op is valid
// - in_ready   out  1      block can accept in_op this cycle
// - in_op      in   IN_W   unsigned operand; held stable by upstream until accepted
// - out_valid  out  1      out_res holds a finished residue
// - out_ready  in   1      downstream consumes out_res this cycle
// - out_res    out  RES_W  residue in_op mod MOD, bit 0 = LSB, always < MOD
// - busy       out  1      high in RUN state
// BEHAVIOUR
// - Reset (async, rst=1):
//   - state=IDLE; acc, shift register and counter cleared.
//   - out_valid=0, out_res=0, busy=0.
//   - in_ready is forced 0 while rst is high.
// - States: IDLE, RUN, HOLD.
// - in_ready = !rst & ((state==IDLE) | (state==HOLD & out_ready)).
// - Accept = in_valid & in_ready.
//   - On accept: sreg<=in_op, acc<=0, cnt<=IN_W-1, state<=RUN.
// - RUN, each cycle:
//   - t = {acc,1'b0} + sreg[IN_W-1]; acc <= (t >= MOD) ? t-MOD : t.
//   - Internal width RES_W+1. One conditional subtract suffices, since t <= 2*MOD-1.
//   - sreg <= sreg << 1; cnt <= cnt-1.
//   - When cnt==0 the last bit is folded in this cycle, and state <= HOLD.
//   - in_valid is ignored in RUN (in_ready=0).
// - HOLD:
//   - out_valid=1, out_res=acc.
//   - Both stay stable while out_ready=0.
//   - out_ready & in_valid: new operand accepted in the same cycle, state <= RUN,
//     out_valid drops next cycle.
//   - out_ready & !in_valid: state <= IDLE.
// - out_valid = (state==HOLD). out_res = acc in HOLD, else 0.
// - Latency: accept on edge k; out_valid is first high after edge k+IN_W.
// - Throughput: one result per IN_W+1 cycles with out_ready tied high and
//   back-to-back in_valid.
// - Boundary values:
//   - in_op=0 -> 0.
//   - in_op=MOD-1 -> MOD-1.
//   - in_op=MOD -> 0.
//   - in_op=all-ones -> (2**IN_W-1) mod MOD.
// - Reset mid-RUN or mid-HOLD aborts the operation. No partial result is ever
//   presented. The next accepted operand reduces correctly.
// - out_res never exceeds MOD-1 in any state. Checked by an assertion in the bench.
// TESTING
// - in_op=0, out_ready=1 -> out_valid after 16 cycles; out_res=0; busy high for
//   exactly 16 cycles.
// - in_op=52 / 53 / 1000 / 65535 -> out_res=52 / 0 / 46 / 27.
// - Backpressure:
//   - in_op=65535, out_ready=0 for 5 cycles -> out_res holds 27, in_ready=0.
//   - Then out_ready=1 with in_valid=1, in_op=106 -> accepted that cycle.
//   - out_valid=0 next cycle; next result out_res=0.
// - Assert rst on the 7th RUN cycle of in_op=40000 -> out_valid=0, busy=0
//   immediately. After release, in_op=40000 -> out_res=38.
// - Streaming:
//   - 2000 random operands; random in_valid/out_ready duty 50%.
//   - Scoreboard checks out_res = in_op % 53, no drops or duplicates.
//   - With ready tied high, the spacing between results is exactly 17 cycles.

Source files
------------

// File: rtl/mod53_serial_reduce_if.sv
// Operand/residue handshake bundle between the operand source, the serial
// reducer and the downstream consumer of the residue.
interface mod53_serial_reduce_if #(
    parameter int IN_W  = 16,
    parameter int RES_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_op;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_res;

    // Source/consumer side: presents operands and consumes residues.
    modport master (
        output in_valid,
        output in_op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_res
    );

    // Reducer side.
    modport slave (
        input  in_valid,
        input  in_op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_res
    );
endinterface

// File: rtl/mod53_serial_reduce.sv
// Bit-serial, MSB-first reduction of an unsigned operand to a residue 0..MOD-1,
// one operand bit per clock, with valid/ready handshakes on both sides.
module mod53_serial_reduce #(
    parameter int IN_W  = 16,
    parameter int MOD   = 53,
    parameter int RES_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    mod53_serial_reduce_if.slave  bus,
    output logic                  busy
);
    localparam int                CNT_W    = $clog2(IN_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [RES_W:0]    MOD_W    = (RES_W + 1)'(MOD);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [RES_W-1:0]   acc_q, acc_d;
    logic [IN_W-1:0]    sreg_q, sreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               accept;
    logic [RES_W:0]     fold_t;
    logic [RES_W:0]     fold_sub;
    logic [RES_W:0]     fold_r;
    logic               unused_fold_msb;

    // Since acc < MOD, t = 2*acc + bit <= 2*MOD-1, so a single conditional
    // subtract keeps the accumulator canonical.
    assign fold_t   = {acc_q, 1'b0} + {{RES_W{1'b0}}, sreg_q[IN_W-1]};
    assign fold_sub = fold_t - MOD_W;
    assign fold_r   = (fold_t >= MOD_W) ? fold_sub : fold_t;
    assign unused_fold_msb = fold_r[RES_W];

    assign bus.in_ready = !rst && ((state_q == ST_IDLE) ||
                                   ((state_q == ST_HOLD) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sreg_d  = bus.in_op;
                    acc_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d  = fold_r[RES_W-1:0];
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q - CNT_ONE;
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Result handed off and a new operand taken in the same cycle.
                if (accept) begin
                    sreg_d  = bus.in_op;
                    acc_d   = '0;
                    cnt_d   = CNT_LAST;
                    state_d = ST_RUN;
                end else if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // The accumulator is only exposed once the last bit has been folded in.
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out_res   = (state_q == ST_HOLD) ? acc_q : '0;
    assign busy          = (state_q == ST_RUN);
endmodule

// File: tb/tb_mod53_serial_reduce.sv
// Randomized and directed bench for mod53_serial_reduce, scoreboarded against
// plain operand % 53 arithmetic.
module tb_mod53_serial_reduce;
    localparam int IN_W  = 16;
    localparam int MOD   = 53;
    localparam int RES_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    int checks  = 0;
    int errors  = 0;
    int results = 0;
    int cyc     = 0;
    int last_cyc = -1;
    bit spacing_on = 1'b0;
    int exp_q[$];

    mod53_serial_reduce_if #(.IN_W(IN_W), .RES_W(RES_W)) dut_if ();

    mod53_serial_reduce #(.IN_W(IN_W), .MOD(MOD), .RES_W(RES_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (dut_if.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rand_op();
        int pick;
        pick = int'($urandom_range(0, 7));
        case (pick)
            0: return 0;
            1: return MOD - 1;
            2: return MOD;
            3: return (1 << IN_W) - 1;
            default: return int'($urandom_range(0, (1 << IN_W) - 1));
        endcase
    endfunction

    // Scoreboard: residues must come out in acceptance order, each exactly once.
    always @(negedge clk) begin
        int op;
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            assert (dut_if.out_res < 6'd53);
            chk("res_range", {31'd0, dut_if.out_res < 6'd53}, 1);
            if (!dut_if.out_valid) chk("res_idle", dut_if.out_res, 0);
            if (dut_if.out_valid && dut_if.out_ready) begin
                chk("pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    op = exp_q.pop_front();
                    chk("residue", dut_if.out_res, op % MOD);
                    $display("result #%0d op=%0d res=%0d cyc=%0d", results, op, dut_if.out_res, cyc);
                end
                results++;
                if (spacing_on) begin
                    if (last_cyc >= 0) chk("spacing", cyc - last_cyc, IN_W + 1);
                    last_cyc = cyc;
                end
            end
            if (dut_if.in_valid && dut_if.in_ready) exp_q.push_back(int'(dut_if.in_op));
        end
    end

    task automatic send(input int op);
        bit got = 1'b0;
        @(posedge clk); #1;
        dut_if.in_valid = 1'b1;
        dut_if.in_op    = IN_W'(op);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (dut_if.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept", got, 1);
        @(posedge clk); #1;
        dut_if.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int res, output int lat, output int busy_n);
        res = -1;
        lat = 999;
        busy_n = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (dut_if.out_valid) begin
                lat = n;
                res = int'(dut_if.out_res);
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic stream_ops(input int n, input bit rnd);
        int  sent = 0;
        int  guard = 0;
        bit  acc;
        @(posedge clk); #1;
        dut_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!rnd || $urandom_range(0, 1) == 1) begin
            dut_if.in_valid = 1'b1;
            dut_if.in_op    = IN_W'(rand_op());
        end
        while (sent < n && guard < 60000) begin
            @(negedge clk);
            acc = dut_if.in_valid && dut_if.in_ready;
            guard++;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                dut_if.in_valid = 1'b0;
            end
            dut_if.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!dut_if.in_valid && sent < n && (!rnd || $urandom_range(0, 1) == 1)) begin
                dut_if.in_valid = 1'b1;
                dut_if.in_op    = IN_W'(rand_op());
            end
        end
        dut_if.in_valid  = 1'b0;
        dut_if.out_ready = 1'b1;
        chk("stream_sent", sent, n);
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !dut_if.out_valid) break;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int res, lat, busy_n, base;
        int dir_op[4]  = '{52, 53, 1000, 65535};
        int dir_exp[4] = '{52, 0, 46, 27};

        dut_if.in_valid  = 1'b0;
        dut_if.in_op     = '0;
        dut_if.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", dut_if.out_valid, 0);
        chk("rst_out_res", dut_if.out_res, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", dut_if.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", dut_if.in_ready, 1);

        // Zero operand: latency and RUN duration.
        dut_if.out_ready = 1'b1;
        send(0);
        wait_result(res, lat, busy_n);
        $display("txn op=0 res=%0d lat=%0d busy=%0d", res, lat, busy_n);
        chk("zero_res", res, 0);
        chk("zero_lat", lat, IN_W);
        chk("zero_busy", busy_n, IN_W);

        foreach (dir_op[i]) begin
            send(dir_op[i]);
            wait_result(res, lat, busy_n);
            $display("txn op=%0d res=%0d lat=%0d", dir_op[i], res, lat);
            chk("dir_res", res, dir_exp[i]);
            chk("dir_lat", lat, IN_W);
        end

        // Backpressure, then hand-off with a simultaneous new operand.
        @(posedge clk); #1;
        dut_if.out_ready = 1'b0;
        send(65535);
        wait_result(res, lat, busy_n);
        chk("bp_res", res, 27);
        @(posedge clk); #1;
        dut_if.in_valid = 1'b1;
        dut_if.in_op    = IN_W'(106);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_res", dut_if.out_res, 27);
            chk("bp_hold_valid", dut_if.out_valid, 1);
            chk("bp_in_ready", dut_if.in_ready, 0);
        end
        @(posedge clk); #1;
        dut_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", dut_if.in_ready, 1);
        @(posedge clk); #1;
        dut_if.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid_drop", dut_if.out_valid, 0);
        chk("bp_busy", busy, 1);
        wait_result(res, lat, busy_n);
        $display("txn op=106 res=%0d lat=%0d", res, lat);
        chk("bp_next_res", res, 0);
        chk("bp_next_lat", lat, IN_W - 1);

        // Reset during the 7th RUN cycle aborts the operation.
        send(40000);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", dut_if.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", dut_if.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(40000);
        wait_result(res, lat, busy_n);
        $display("txn op=40000 res=%0d lat=%0d", res, lat);
        chk("post_rst_res", res, 38);
        chk("post_rst_lat", lat, IN_W);

        // Random streaming with random valid/ready.
        drain();
        base = results;
        stream_ops(2000, 1'b1);
        drain();
        chk("stream_count", results - base, 2000);

        // Back-to-back with ready tied high: fixed result spacing.
        last_cyc   = -1;
        spacing_on = 1'b1;
        base = results;
        stream_ops(20, 1'b0);
        drain();
        spacing_on = 1'b0;
        chk("b2b_count", results - base, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
